// File: rtl/sdram_responder.sv
// -----------------------------------------------------------------------------
// sdram_responder
//
// Behavioural SDRAM device responder for exercising an SDR SDRAM controller.
// It decodes the command strobes every cycle, tracks per-bank open/idle state
// with a tRCD timer per bank, holds the mode register (CAS latency), stores the
// data array, returns read data at the programmed CAS latency, and flags
// protocol violations with a sticky error code.
//
// Ports
//   clk            clock, all logic on the rising edge
//   init           synchronous active-high reset
//   sd_cs/ras/cas/we  active-low command strobes
//   sd_ba          bank select
//   sd_addr        row / column / mode word; addr[10] selects precharge-all
//                  or auto-precharge
//   sd_dqm         byte masks (bit1 -> [15:8], bit0 -> [7:0]), 1 = masked
//   sd_dq_in       write data, sampled on the WRITE command edge
//   sd_dq_out      read data, valid for one cycle ending at edge READ+CL
//   sd_dq_oe       per-byte output enable for sd_dq_out
//   ready          mode register has been loaded
//   err            sticky protocol error flag
//   err_code       code of the first error since reset
//   refresh_count  number of accepted AUTO_REFRESH commands, saturating
//
// Error codes
//   1 command needing the mode register before it is loaded
//   2 ACTIVE to an open bank
//   3 READ/WRITE to an idle bank
//   4 READ/WRITE before tRCD has elapsed
//   5 AUTO_REFRESH with a bank open
//   6 illegal LOAD_MODE
// A rejected command changes no state other than err/err_code.
// -----------------------------------------------------------------------------
module sdram_responder #(
   parameter int ROW_BITS = 4,
   parameter int RCD      = 2
) (
   input  logic        clk,
   input  logic        init,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   input  logic [1:0]  sd_ba,
   input  logic [12:0] sd_addr,
   input  logic [1:0]  sd_dqm,
   input  logic [15:0] sd_dq_in,
   output logic [15:0] sd_dq_out,
   output logic [1:0]  sd_dq_oe,
   output logic        ready,
   output logic        err,
   output logic [2:0]  err_code,
   output logic [15:0] refresh_count
);

   // Word address is {bank, low row bits, column}.
   localparam int MEM_AW    = 2 + ROW_BITS + 9;
   localparam int MEM_WORDS = 1 << MEM_AW;

   localparam logic [7:0] RCD_INIT = 8'(RCD);

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_NOT_READY = 3'd1;
   localparam logic [2:0] ERR_ACT_OPEN  = 3'd2;
   localparam logic [2:0] ERR_BANK_IDLE = 3'd3;
   localparam logic [2:0] ERR_TRCD      = 3'd4;
   localparam logic [2:0] ERR_REF_OPEN  = 3'd5;
   localparam logic [2:0] ERR_BAD_MODE  = 3'd6;

   typedef enum logic [3:0] {
      CMD_INHIBIT,
      CMD_NOP,
      CMD_ACTIVE,
      CMD_READ,
      CMD_WRITE,
      CMD_PRECHARGE,
      CMD_REFRESH,
      CMD_LOAD_MODE,
      CMD_BURST_TERM
   } cmd_t;

   typedef enum logic {
      BANK_IDLE,
      BANK_OPEN
   } bank_state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   bank_state_t         bank_st  [4];
   logic [ROW_BITS-1:0] open_row [4];
   logic [7:0]          trcd_cnt [4];

   logic [2:0]          cas_lat;
   logic                wb_mode;

   // Read return pipeline: p0 is loaded on the READ edge, p1 one cycle
   // later, and the output register takes p0 (CL=2) or p1 (CL=3). Together
   // with the output register this is three stages, enough for CL=3
   // reads issued on every cycle.
   logic [1:0]          p0_oe;
   logic [15:0]         p0_data;
   logic [1:0]          p1_oe;
   logic [15:0]         p1_data;

   // Data array kept as two byte lanes so byte masking is a plain
   // per-lane write enable. Never reset: contents survive init.
   logic [7:0]          mem_lo [MEM_WORDS];
   logic [7:0]          mem_hi [MEM_WORDS];

   // ---------------------------------------------------------------------
   // Command decode
   // ---------------------------------------------------------------------
   cmd_t cmd;

   always_comb begin
      cmd = CMD_NOP;
      if (sd_cs) begin
         cmd = CMD_INHIBIT;
      end else begin
         case ({sd_ras, sd_cas, sd_we})
            3'b111:  cmd = CMD_NOP;
            3'b011:  cmd = CMD_ACTIVE;
            3'b101:  cmd = CMD_READ;
            3'b100:  cmd = CMD_WRITE;
            3'b010:  cmd = CMD_PRECHARGE;
            3'b001:  cmd = CMD_REFRESH;
            3'b000:  cmd = CMD_LOAD_MODE;
            default: cmd = CMD_BURST_TERM;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Legality check for the command on this edge
   // ---------------------------------------------------------------------
   logic       any_open;
   logic       sel_open;
   logic       sel_trcd_busy;
   logic       mode_ok;
   logic [2:0] err_now;

   always_comb begin
      any_open = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (bank_st[b] == BANK_OPEN) any_open = 1'b1;
      end
      sel_open = (bank_st[sd_ba] == BANK_OPEN);
      // The counter is loaded with RCD on ACTIVE and decremented on each
      // later edge, so a value of 1 or 0 here means at least RCD cycles
      // have passed since the ACTIVE.
      sel_trcd_busy = (trcd_cnt[sd_ba] > 8'd1);
      mode_ok = !any_open &&
                ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) &&
                (sd_addr[2:0] == 3'b000);

      err_now = ERR_NONE;
      case (cmd)
         CMD_ACTIVE: begin
            if (!ready)        err_now = ERR_NOT_READY;
            else if (sel_open) err_now = ERR_ACT_OPEN;
         end
         CMD_READ, CMD_WRITE: begin
            if (!ready)             err_now = ERR_NOT_READY;
            else if (!sel_open)     err_now = ERR_BANK_IDLE;
            else if (sel_trcd_busy) err_now = ERR_TRCD;
         end
         CMD_REFRESH: begin
            if (any_open) err_now = ERR_REF_OPEN;
         end
         CMD_LOAD_MODE: begin
            if (!mode_ok) err_now = ERR_BAD_MODE;
         end
         default: err_now = ERR_NONE;
      endcase
   end

   logic rd_ok;
   logic wr_ok;

   assign rd_ok = (cmd == CMD_READ)  && (err_now == ERR_NONE);
   assign wr_ok = (cmd == CMD_WRITE) && (err_now == ERR_NONE);

   // ---------------------------------------------------------------------
   // Data array
   // ---------------------------------------------------------------------
   logic [MEM_AW-1:0] mem_addr;
   logic [15:0]       rd_word;

   assign mem_addr = {sd_ba, open_row[sd_ba], sd_addr[8:0]};
   // Sampled on the command edge, so a READ followed by a WRITE to the same
   // word captures the value from before that WRITE.
   assign rd_word  = {mem_hi[mem_addr], mem_lo[mem_addr]};

   always_ff @(posedge clk) begin
      if (wr_ok && !init) begin
         if (!sd_dqm[0]) mem_lo[mem_addr] <= sd_dq_in[7:0];
         if (!sd_dqm[1]) mem_hi[mem_addr] <= sd_dq_in[15:8];
      end
   end

   // ---------------------------------------------------------------------
   // Bank, mode, error, refresh and read pipeline state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (init) begin
         for (int b = 0; b < 4; b++) begin
            bank_st[b]  <= BANK_IDLE;
            open_row[b] <= '0;
            trcd_cnt[b] <= 8'd0;
         end
         cas_lat       <= 3'd3;
         wb_mode       <= 1'b0;
         p0_oe         <= 2'b00;
         p0_data       <= 16'h0000;
         p1_oe         <= 2'b00;
         p1_data       <= 16'h0000;
         sd_dq_oe      <= 2'b00;
         sd_dq_out     <= 16'h0000;
         ready         <= 1'b0;
         err           <= 1'b0;
         err_code      <= 3'd0;
         refresh_count <= 16'h0000;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (trcd_cnt[b] != 8'd0) trcd_cnt[b] <= trcd_cnt[b] - 8'd1;
         end

         if (err_now != ERR_NONE) begin
            err <= 1'b1;
            if (!err) err_code <= err_now;
         end

         // An accepted WRITE takes the data bus: every read not yet on the
         // bus, including one that would appear this cycle, is dropped.
         // A rejected READ enters the pipe as an empty slot.
         if (wr_ok) begin
            p0_oe     <= 2'b00;
            p0_data   <= 16'h0000;
            p1_oe     <= 2'b00;
            p1_data   <= 16'h0000;
            sd_dq_oe  <= 2'b00;
            sd_dq_out <= 16'h0000;
         end else begin
            p0_oe   <= rd_ok ? ~sd_dqm : 2'b00;
            p0_data <= rd_ok ? rd_word : 16'h0000;
            p1_oe   <= p0_oe;
            p1_data <= p0_data;
            if (cas_lat == 3'd2) begin
               sd_dq_oe  <= p0_oe;
               sd_dq_out <= p0_data;
            end else begin
               sd_dq_oe  <= p1_oe;
               sd_dq_out <= p1_data;
            end
         end

         case (cmd)
            CMD_ACTIVE: begin
               if (err_now == ERR_NONE) begin
                  bank_st[sd_ba]  <= BANK_OPEN;
                  open_row[sd_ba] <= sd_addr[ROW_BITS-1:0];
                  trcd_cnt[sd_ba] <= RCD_INIT;
               end
            end
            CMD_READ, CMD_WRITE: begin
               if ((err_now == ERR_NONE) && sd_addr[10]) begin
                  bank_st[sd_ba] <= BANK_IDLE;
               end
            end
            CMD_PRECHARGE: begin
               if (sd_addr[10]) begin
                  for (int b = 0; b < 4; b++) bank_st[b] <= BANK_IDLE;
               end else begin
                  bank_st[sd_ba] <= BANK_IDLE;
               end
            end
            CMD_REFRESH: begin
               if ((err_now == ERR_NONE) && (refresh_count != 16'hFFFF)) begin
                  refresh_count <= refresh_count + 16'd1;
               end
            end
            CMD_LOAD_MODE: begin
               if (err_now == ERR_NONE) begin
                  cas_lat <= sd_addr[6:4];
                  wb_mode <= sd_addr[9];
                  ready   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Upper address bits beyond the stored row, and the write-burst mode bit
   // (no effect while burst length is fixed at one), are not otherwise used.
   logic unused_bits;
   assign unused_bits = ^{sd_addr[12:11], wb_mode};

endmodule

// File: tb/tb_sdram_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_responder
//
// Drives sdram_responder one command per cycle and compares every output,
// every cycle, with a behavioural model: per-bank open flag/row/activate
// cycle, a word-keyed memory, and a queue of expected read returns tagged
// with the cycle on which they must be on the bus. Directed scenarios add
// constant expectations for the key cases.
// -----------------------------------------------------------------------------
module tb_sdram_responder;

   localparam int RCD = 2;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;
   localparam logic [3:0] C_BST = 4'b0110;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        init;
   logic        sd_cs, sd_ras, sd_cas, sd_we;
   logic [1:0]  sd_ba;
   logic [12:0] sd_addr;
   logic [1:0]  sd_dqm;
   logic [15:0] sd_dq_in;
   logic [15:0] sd_dq_out;
   logic [1:0]  sd_dq_oe;
   logic        ready;
   logic        err;
   logic [2:0]  err_code;
   logic [15:0] refresh_count;

   always #5 clk = ~clk;

   sdram_responder #(.ROW_BITS(4), .RCD(RCD)) dut (
      .clk           (clk),
      .init          (init),
      .sd_cs         (sd_cs),
      .sd_ras        (sd_ras),
      .sd_cas        (sd_cas),
      .sd_we         (sd_we),
      .sd_ba         (sd_ba),
      .sd_addr       (sd_addr),
      .sd_dqm        (sd_dqm),
      .sd_dq_in      (sd_dq_in),
      .sd_dq_out     (sd_dq_out),
      .sd_dq_oe      (sd_dq_oe),
      .ready         (ready),
      .err           (err),
      .err_code      (err_code),
      .refresh_count (refresh_count)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   int          cyc = 0;
   bit          m_open [4];
   int          m_row  [4];
   int          m_act  [4];
   bit          m_ready;
   bit          m_err;
   int          m_code;
   int          m_ref;
   int          m_cl = 3;
   logic [15:0] m_mem [int];
   // {due cycle[31:0], oe[1:0], data[15:0]}
   logic [49:0] exp_q [$];
   logic [1:0]  e_oe;
   logic [15:0] e_data;

   function automatic int key_of(input int ba, input int row, input int col);
      return ba * 8192 + (row % 16) * 512 + col;
   endfunction

   task automatic model_edge(input bit i_init, input logic [3:0] c, input logic [1:0] ba,
                             input logic [12:0] addr, input logic [1:0] dqm, input logic [15:0] din);
      int          code;
      int          key;
      bit          any_open;
      logic [15:0] old;
      cyc++;
      if (i_init) begin
         for (int b = 0; b < 4; b++) m_open[b] = 0;
         m_ready = 0;
         m_err   = 0;
         m_code  = 0;
         m_ref   = 0;
         exp_q.delete();
      end else if (!c[3]) begin
         any_open = 0;
         for (int b = 0; b < 4; b++) any_open |= m_open[b];
         code = 0;
         if (!m_ready && (c == C_ACT || c == C_RD || c == C_WR)) code = 1;
         else if (c == C_ACT && m_open[ba]) code = 2;
         else if ((c == C_RD || c == C_WR) && !m_open[ba]) code = 3;
         else if ((c == C_RD || c == C_WR) && (cyc - m_act[ba] < RCD)) code = 4;
         else if (c == C_REF && any_open) code = 5;
         else if (c == C_LMR && (any_open || !(addr[6:4] == 3'd2 || addr[6:4] == 3'd3) ||
                                 addr[2:0] != 3'd0)) code = 6;
         if (code != 0) begin
            if (!m_err) m_code = code;
            m_err = 1;
         end else begin
            key = key_of(int'(ba), m_row[ba], int'(addr[8:0]));
            case (c)
               C_ACT: begin
                  m_open[ba] = 1;
                  m_row[ba]  = int'(addr);
                  m_act[ba]  = cyc;
               end
               C_RD: begin
                  old = m_mem.exists(key) ? m_mem[key] : 16'h0000;
                  exp_q.push_back({32'(cyc + m_cl - 1), ~dqm, old});
                  if (addr[10]) m_open[ba] = 0;
               end
               C_WR: begin
                  exp_q.delete();
                  old = m_mem.exists(key) ? m_mem[key] : 16'h0000;
                  m_mem[key] = {dqm[1] ? old[15:8] : din[15:8], dqm[0] ? old[7:0] : din[7:0]};
                  if (addr[10]) m_open[ba] = 0;
               end
               C_PRE: begin
                  if (addr[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
                  else m_open[ba] = 0;
               end
               C_REF: if (m_ref < 65535) m_ref++;
               C_LMR: begin
                  m_cl    = int'(addr[6:4]);
                  m_ready = 1;
               end
               default: ;
            endcase
         end
      end
      e_oe   = 2'b00;
      e_data = 16'h0000;
      if (exp_q.size() > 0 && exp_q[0][49:18] == 32'(cyc)) begin
         e_oe   = exp_q[0][17:16];
         e_data = exp_q[0][15:0];
         void'(exp_q.pop_front());
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic step(input bit i_init, input logic [3:0] c, input logic [1:0] ba,
                       input logic [12:0] addr, input logic [1:0] dqm, input logic [15:0] din);
      init = i_init;
      {sd_cs, sd_ras, sd_cas, sd_we} = c;
      sd_ba    = ba;
      sd_addr  = addr;
      sd_dqm   = dqm;
      sd_dq_in = din;
      @(posedge clk);
      model_edge(i_init, c, ba, addr, dqm, din);
      @(negedge clk);
      check("dq_out",   32'(sd_dq_out),     32'(e_data));
      check("dq_oe",    32'(sd_dq_oe),      32'(e_oe));
      check("ready",    32'(ready),         32'(m_ready));
      check("err",      32'(err),           32'(m_err));
      check("err_code", 32'(err_code),      32'(m_code));
      check("refresh",  32'(refresh_count), 32'(m_ref));
   endtask

   task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr,
                      input logic [1:0] dqm = 2'b00, input logic [15:0] din = 16'h0000);
      step(1'b0, c, ba, addr, dqm, din);
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0);
   endtask

   task automatic rst(input int n);
      for (int i = 0; i < n; i++) step(1'b1, C_NOP, 2'd0, 13'd0, 2'b00, 16'h0000);
   endtask

   task automatic random_phase(input int n);
      int          r;
      logic [1:0]  ba;
      logic [12:0] col;
      logic [1:0]  dqm;
      for (int i = 0; i < n; i++) begin
         r   = $urandom_range(0, 99);
         ba  = 2'($urandom_range(0, 3));
         col = 13'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 13'h400 : 13'h000);
         dqm = 2'($urandom_range(0, 3));
         if (r < 12)      cmd(C_ACT, ba, 13'($urandom_range(0, 3)));
         else if (r < 40) cmd(C_RD, ba, col, dqm);
         else if (r < 55) cmd(C_WR, ba, col, dqm, 16'($urandom));
         else if (r < 64) cmd(C_PRE, ba, ($urandom_range(0, 3) == 0) ? 13'h400 : 13'h000);
         else if (r < 67) cmd(C_REF, ba, 13'd0);
         else if (r < 70) cmd(C_BST, ba, 13'd0);
         else if (r < 74) cmd({1'b1, 3'($urandom_range(0, 7))}, ba, col);
         else             nop(1);
      end
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      init = 1'b1;
      {sd_cs, sd_ras, sd_cas, sd_we} = 4'b1111;
      sd_ba = 2'd0; sd_addr = 13'd0; sd_dqm = 2'b00; sd_dq_in = 16'h0000;

      rst(2);
      check("rst_oe", 32'(sd_dq_oe), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);

      // CL=2, fill banks 0-3 rows 0-3 cols 0-3 so random reads hit known words
      cmd(C_PRE, 2'd0, 13'h400);
      cmd(C_LMR, 2'd0, 13'h020);
      check("up_ready", 32'(ready), 32'd1);
      for (int b = 0; b < 4; b++) begin
         for (int r = 0; r < 4; r++) begin
            cmd(C_ACT, 2'(b), 13'(r));
            nop(1);
            for (int c = 0; c < 4; c++) cmd(C_WR, 2'(b), 13'(c), 2'b00, 16'($urandom));
            cmd(C_PRE, 2'(b), 13'd0);
         end
      end
      random_phase(300);
      cmd(C_PRE, 2'd0, 13'h400);
      nop(3);
      cmd(C_LMR, 2'd0, 13'h030);
      random_phase(300);

      // bring-up with mode word 0x230
      rst(1);
      cmd(C_PRE, 2'd0, 13'h400);
      cmd(C_LMR, 2'd0, 13'h230);
      check("s1_ready", 32'(ready), 32'd1);
      check("s1_err", 32'(err), 32'd0);

      // write then read, CL=3
      cmd(C_ACT, 2'd1, 13'd5);
      nop(2);
      cmd(C_WR, 2'd1, 13'h01F, 2'b00, 16'hA55A);
      cmd(C_RD, 2'd1, 13'h01F, 2'b00);
      nop(2);
      check("s2_data", 32'(sd_dq_out), 32'hA55A);
      check("s2_oe", 32'(sd_dq_oe), 32'h3);

      // byte masking on write and read
      cmd(C_WR, 2'd1, 13'h020, 2'b00, 16'h1234);
      cmd(C_WR, 2'd1, 13'h020, 2'b10, 16'hFFFF);
      cmd(C_RD, 2'd1, 13'h020, 2'b00);
      nop(2);
      check("s3_data", 32'(sd_dq_out), 32'h12FF);
      cmd(C_RD, 2'd1, 13'h020, 2'b01);
      nop(2);
      check("s3_oe_mask", 32'(sd_dq_oe), 32'h2);

      // row 21 aliases onto row 5
      cmd(C_PRE, 2'd1, 13'd0);
      cmd(C_ACT, 2'd1, 13'd21);
      nop(1);
      cmd(C_RD, 2'd1, 13'h01F, 2'b00);
      nop(2);
      check("alias_data", 32'(sd_dq_out), 32'hA55A);

      // READ one cycle after ACTIVE
      rst(1);
      cmd(C_LMR, 2'd0, 13'h030);
      cmd(C_ACT, 2'd2, 13'd0);
      cmd(C_RD, 2'd2, 13'h001, 2'b00);
      check("s4_err", 32'(err), 32'd1);
      check("s4_code", 32'(err_code), 32'd4);
      nop(2);
      check("s4_slot_oe", 32'(sd_dq_oe), 32'd0);

      // three back-to-back READs, WRITE one cycle after the last
      rst(1);
      cmd(C_LMR, 2'd0, 13'h030);
      cmd(C_REF, 2'd0, 13'd0);
      check("s5_ref", 32'(refresh_count), 32'd1);
      cmd(C_ACT, 2'd0, 13'd1);
      nop(1);
      cmd(C_RD, 2'd0, 13'd0);
      cmd(C_RD, 2'd0, 13'd1);
      cmd(C_RD, 2'd0, 13'd2);
      check("s5_first_oe", 32'(sd_dq_oe), 32'h3);
      check("s5_first", 32'(sd_dq_out), 32'(m_mem[key_of(0, 1, 0)]));
      nop(1);
      check("s5_second", 32'(sd_dq_out), 32'(m_mem[key_of(0, 1, 1)]));
      cmd(C_WR, 2'd0, 13'd3, 2'b00, 16'h5A5A);
      check("s5_flushed", 32'(sd_dq_oe), 32'd0);
      nop(2);
      check("s5_err", 32'(err), 32'd0);

      // AUTO_REFRESH with bank0 open
      cmd(C_REF, 2'd0, 13'd0);
      check("s6_code", 32'(err_code), 32'd5);
      check("s6_ref", 32'(refresh_count), 32'd1);

      // init while a READ is in flight
      cmd(C_RD, 2'd0, 13'd1);
      rst(1);
      check("mid_oe", 32'(sd_dq_oe), 32'd0);
      check("mid_out", 32'(sd_dq_out), 32'd0);
      check("mid_ref", 32'(refresh_count), 32'd0);
      check("mid_code", 32'(err_code), 32'd0);
      nop(2);
      cmd(C_ACT, 2'd0, 13'd1);
      check("notready_code", 32'(err_code), 32'd1);
      rst(1);
      cmd(C_LMR, 2'd0, 13'h030);
      cmd(C_ACT, 2'd0, 13'd1);
      nop(1);
      cmd(C_RD, 2'd0, 13'd1);
      nop(2);
      check("retained", 32'(sd_dq_out), 32'(m_mem[key_of(0, 1, 1)]));

      // remaining error codes
      rst(1);
      cmd(C_LMR, 2'd0, 13'h020);
      cmd(C_ACT, 2'd3, 13'd0);
      cmd(C_ACT, 2'd3, 13'd1);
      check("act_open_code", 32'(err_code), 32'd2);
      rst(1);
      cmd(C_LMR, 2'd0, 13'h020);
      cmd(C_RD, 2'd3, 13'd0);
      check("idle_code", 32'(err_code), 32'd3);
      rst(1);
      cmd(C_LMR, 2'd0, 13'h031);
      check("bad_mode_code", 32'(err_code), 32'd6);
      check("bad_mode_ready", 32'(ready), 32'd0);
      nop(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
